// File: rtl/ic_pkg.sv
// ============================================================================
// Package  : ic_pkg
// Purpose  : Shared interconnect widths, request/response bundles and helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ic_pkg;

   localparam int IC_ADDR_W = 32;
   localparam int IC_DATA_W = 32;
   localparam int IC_STRB_W = 4;

   typedef struct packed {
      logic                 wen;
      logic [IC_STRB_W-1:0] strb;
      logic [IC_DATA_W-1:0] wdata;
      logic [IC_ADDR_W-1:0] addr;
   } ic_req_t;

   typedef struct packed {
      logic                 error;
      logic [IC_DATA_W-1:0] rdata;
   } ic_rsp_t;

   // Ceiling log2, usable in constant expressions.
   function automatic int ic_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ic_id_fifo.sv
// ============================================================================
// Module   : ic_id_fifo
// Purpose  : Small FIFO of requester IDs for in-order response routing.
//            Push is ignored when full, pop is ignored when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ic_id_fifo
   import ic_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int AW = (DEPTH > 1) ? ic_clog2(DEPTH) : 1;
   localparam int CW = ic_clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer and occupancy next-state; pointers wrap explicitly at DEPTH-1.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   // Control registers, synchronous reset to empty.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge g_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/ic_cpu_bus_arbiter.sv
// ============================================================================
// Module   : ic_cpu_bus_arbiter
// Purpose  : NREQ-way arbiter onto one req/gnt + recv/ack memory bus with
//            in-order outstanding responses routed via an ID FIFO.
//            IC_ARB_RR_EN defined -> round-robin, else fixed priority (idx 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ic_cpu_bus_arbiter
   import ic_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int OUTSTANDING = 2
) (
   input  logic                        g_clk,
   input  logic                        g_resetn,
   input  logic [NREQ-1:0]             s_mem_req,
   input  logic [NREQ-1:0]             s_mem_wen,
   input  logic [IC_STRB_W*NREQ-1:0]   s_mem_strb,
   input  logic [IC_DATA_W*NREQ-1:0]   s_mem_wdata,
   input  logic [IC_ADDR_W*NREQ-1:0]   s_mem_addr,
   output logic [NREQ-1:0]             s_mem_gnt,
   output logic [NREQ-1:0]             s_mem_recv,
   input  logic [NREQ-1:0]             s_mem_ack,
   output logic [NREQ-1:0]             s_mem_error,
   output logic [IC_DATA_W*NREQ-1:0]   s_mem_rdata,
   output logic                        m_mem_req,
   output logic                        m_mem_wen,
   output logic [IC_STRB_W-1:0]        m_mem_strb,
   output logic [IC_DATA_W-1:0]        m_mem_wdata,
   output logic [IC_ADDR_W-1:0]        m_mem_addr,
   input  logic                        m_mem_gnt,
   input  logic                        m_mem_recv,
   output logic                        m_mem_ack,
   input  logic                        m_mem_error,
   input  logic [IC_DATA_W-1:0]        m_mem_rdata
);

   localparam int IDW = ic_clog2(NREQ);

   ic_req_t          req_vec [NREQ];
   ic_req_t          req_sel;
   ic_rsp_t          rsp;
   logic [IDW-1:0]   pick, sel, head;
   logic             lock_vld_q, lock_vld_d;
   logic [IDW-1:0]   lock_id_q,  lock_id_d;
   logic             fifo_full, fifo_empty;
   logic             accept, pop, pend_hold_lost;

   // Unpack the flat requester buses into per-requester bundles.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_vec[i].wen   = s_mem_wen[i];
         req_vec[i].strb  = s_mem_strb [IC_STRB_W*i +: IC_STRB_W];
         req_vec[i].wdata = s_mem_wdata[IC_DATA_W*i +: IC_DATA_W];
         req_vec[i].addr  = s_mem_addr [IC_ADDR_W*i +: IC_ADDR_W];
      end
   end

`ifdef IC_ARB_RR_EN
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   // Round-robin pick: first requester at or after rr_ptr, wrapping.
   always_comb begin
      logic found;
      int   idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && s_mem_req[idx]) begin
            pick  = IDW'(idx);
            found = 1'b1;
         end
      end
      rr_ptr_d = rr_ptr_q;
      if (accept) rr_ptr_d = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
   end

   // Round-robin pointer register.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) rr_ptr_q <= '0;
      else           rr_ptr_q <= rr_ptr_d;
   end
`else
   // Fixed priority pick: lowest requesting index wins.
   always_comb begin
      pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (s_mem_req[i]) pick = IDW'(i);
      end
   end
`endif

   // A stalled request keeps its winner so the payload cannot change under it.
   // If the locked requester withdraws (bus-rule violation) the lock is dropped
   // rather than stalling the bus forever.
   assign sel            = lock_vld_q ? lock_id_q : pick;
   assign pend_hold_lost = lock_vld_q && !s_mem_req[lock_id_q];
   assign m_mem_req      = (|s_mem_req) && !fifo_full && !pend_hold_lost;
   assign accept         = m_mem_req && m_mem_gnt;
   assign s_mem_gnt      = accept ? (NREQ'(1) << sel) : '0;

   assign req_sel     = req_vec[sel];
   assign m_mem_wen   = req_sel.wen;
   assign m_mem_strb  = req_sel.strb;
   assign m_mem_wdata = req_sel.wdata;
   assign m_mem_addr  = req_sel.addr;

   // Lock next-state: set on a stalled request, cleared on accept or withdrawal.
   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
      if (accept) begin
         lock_vld_d = 1'b0;
      end else if (pend_hold_lost) begin
         lock_vld_d = 1'b0;
      end else if (m_mem_req) begin
         lock_vld_d = 1'b1;
         lock_id_d  = sel;
      end
   end

   // Lock register.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         lock_vld_q <= 1'b0;
         lock_id_q  <= '0;
      end else begin
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
      end
   end

   // Responses return in issue order; only the head requester may consume one.
   assign s_mem_recv = (m_mem_recv && !fifo_empty) ? (NREQ'(1) << head) : '0;
   assign m_mem_ack  = !fifo_empty && s_mem_ack[head];
   assign pop        = m_mem_recv && m_mem_ack;

   assign rsp         = '{error: m_mem_error, rdata: m_mem_rdata};
   assign s_mem_error = {NREQ{rsp.error}};
   assign s_mem_rdata = {NREQ{rsp.rdata}};

   ic_id_fifo #(
      .WIDTH (IDW),
      .DEPTH (OUTSTANDING)
   ) u_id_fifo (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .push_i   (accept),
      .data_i   (sel),
      .pop_i    (pop),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .head_o   (head)
   );

`ifndef SYNTHESIS
   // A response with nothing outstanding means the downstream broke protocol.
   always_ff @(posedge g_clk) begin
      assert (!(g_resetn && m_mem_recv && fifo_empty))
         else $error("ic_cpu_bus_arbiter: response received with no outstanding request");
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ic_cpu_bus_arbiter.sv
// ============================================================================
// Module   : tb_ic_cpu_bus_arbiter
// Purpose  : Directed self-checking bench for ic_cpu_bus_arbiter (NREQ=2,
//            OUTSTANDING=2); expectations follow IC_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ic_cpu_bus_arbiter;

`ifdef IC_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          g_clk = 1'b0;
   logic          g_resetn;
   logic [1:0]    s_req, s_wen, s_ack;
   logic [7:0]    s_strb;
   logic [63:0]   s_wdata, s_addr;
   logic [1:0]    s_gnt, s_recv, s_error;
   logic [63:0]   s_rdata;
   logic          m_req, m_wen, m_gnt, m_recv, m_ack, m_error;
   logic [3:0]    m_strb;
   logic [31:0]   m_wdata, m_addr, m_rdata;

   int total  = 0;
   int passed = 0;

   always #5 g_clk = ~g_clk;

   ic_cpu_bus_arbiter #(.NREQ(2), .OUTSTANDING(2)) dut (
      .g_clk       (g_clk),
      .g_resetn    (g_resetn),
      .s_mem_req   (s_req),
      .s_mem_wen   (s_wen),
      .s_mem_strb  (s_strb),
      .s_mem_wdata (s_wdata),
      .s_mem_addr  (s_addr),
      .s_mem_gnt   (s_gnt),
      .s_mem_recv  (s_recv),
      .s_mem_ack   (s_ack),
      .s_mem_error (s_error),
      .s_mem_rdata (s_rdata),
      .m_mem_req   (m_req),
      .m_mem_wen   (m_wen),
      .m_mem_strb  (m_strb),
      .m_mem_wdata (m_wdata),
      .m_mem_addr  (m_addr),
      .m_mem_gnt   (m_gnt),
      .m_mem_recv  (m_recv),
      .m_mem_ack   (m_ack),
      .m_mem_error (m_error),
      .m_mem_rdata (m_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Inputs change just after the falling edge; checks follow 1 time unit later.
   task automatic step();
      @(negedge g_clk);
   endtask

   initial begin
      g_resetn = 1'b0;
      s_req = '0; s_wen = '0; s_ack = '0; s_strb = '0; s_wdata = '0; s_addr = '0;
      m_gnt = 1'b0; m_recv = 1'b0; m_error = 1'b0; m_rdata = '0;
      step(); step(); #1;
      chk("rst_m_req",  m_req,  0);
      chk("rst_m_ack",  m_ack,  0);
      chk("rst_s_gnt",  s_gnt,  0);
      chk("rst_s_recv", s_recv, 0);

      // 1: single request passes straight through, response routed back
      step(); g_resetn = 1'b1;
      s_req = 2'b01; s_addr[31:0] = 32'h1000; s_wen = 2'b01; s_strb[3:0] = 4'hF;
      s_wdata[31:0] = 32'hDEAD_BEEF; m_gnt = 1'b1; #1;
      chk("t1_m_req",   m_req,   1);
      chk("t1_m_addr",  m_addr,  32'h1000);
      chk("t1_m_wdata", m_wdata, 32'hDEAD_BEEF);
      chk("t1_m_wen",   m_wen,   1);
      chk("t1_m_strb",  m_strb,  4'hF);
      chk("t1_s_gnt",   s_gnt,   2'b01);
      step(); s_req = 2'b00; s_wen = 2'b00; m_gnt = 1'b0;
      m_recv = 1'b1; s_ack = 2'b01; m_rdata = 32'hCAFE_0001; #1;
      chk("t1_s_recv",  s_recv,  2'b01);
      chk("t1_m_ack",   m_ack,   1);
      chk("t1_rdata",   s_rdata, 64'hCAFE_0001_CAFE_0001);
      step(); m_recv = 1'b0; s_ack = 2'b00; #1;
      chk("t1_idle_req", m_req, 0);

      // reset so both builds start test 2 with rr_ptr = 0
      step(); g_resetn = 1'b0;
      step(); g_resetn = 1'b1;

      // 2: both requesters held, responses acked every cycle
      s_req = 2'b11; s_addr = {32'h200, 32'h100}; m_gnt = 1'b1; s_ack = 2'b11; #1;
      chk("t2_gnt_a",  s_gnt,  2'b01);
      chk("t2_addr_a", m_addr, 32'h100);
      step(); m_recv = 1'b1; #1;
      chk("t2_recv_b", s_recv, 2'b01);
      chk("t2_ack_b",  m_ack,  1);
      chk("t2_gnt_b",  s_gnt,  RR ? 2'b10 : 2'b01);
      chk("t2_addr_b", m_addr, RR ? 32'h200 : 32'h100);
      step(); #1;
      chk("t2_recv_c", s_recv, RR ? 2'b10 : 2'b01);
      chk("t2_gnt_c",  s_gnt,  2'b01);
      step(); s_req = 2'b00; m_gnt = 1'b0; #1;
      chk("t2_recv_d", s_recv, 2'b01);
      chk("t2_req_d",  m_req,  0);
      step(); m_recv = 1'b0; s_ack = 2'b00;

      // 3: stalled s1 request stays locked when s0 arrives
      s_req = 2'b10; s_addr = {32'h2000, 32'h3000}; #1;
      chk("t3_req_1",  m_req,  1);
      chk("t3_addr_1", m_addr, 32'h2000);
      chk("t3_gnt_1",  s_gnt,  2'b00);
      step(); s_req = 2'b11; #1;
      chk("t3_addr_2", m_addr, 32'h2000);
      chk("t3_gnt_2",  s_gnt,  2'b00);
      step(); #1;
      chk("t3_addr_3", m_addr, 32'h2000);
      step(); m_gnt = 1'b1; #1;
      chk("t3_gnt_4",  s_gnt,  2'b10);
      chk("t3_addr_4", m_addr, 32'h2000);
      step(); s_req = 2'b01; #1;
      chk("t3_gnt_5",  s_gnt,  2'b01);
      chk("t3_addr_5", m_addr, 32'h3000);

      // 4: FIFO full blocks requests; pop lets a request through next cycle
      step(); s_addr[31:0] = 32'h4000; #1;
      chk("t4_full_req", m_req, 0);
      chk("t4_full_gnt", s_gnt, 2'b00);
      step(); m_recv = 1'b1; s_ack = 2'b10; #1;
      chk("t4_pop_recv", s_recv, 2'b10);
      chk("t4_pop_ack",  m_ack,  1);
      chk("t4_pop_req",  m_req,  0);
      step(); m_recv = 1'b0; s_ack = 2'b00; #1;
      chk("t4_after_req",  m_req,  1);
      chk("t4_after_gnt",  s_gnt,  2'b01);
      chk("t4_after_addr", m_addr, 32'h4000);
      step(); s_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1; s_ack = 2'b01; #1;
      chk("t4_drain_1", s_recv, 2'b01);
      step(); #1;
      chk("t4_drain_2", s_recv, 2'b01);
      chk("t4_drain_ack", m_ack, 1);
      step(); m_recv = 1'b0; s_ack = 2'b00;

      // 5: in-order responses; head waits for its own ack
      s_req = 2'b01; m_gnt = 1'b1; #1;
      chk("t5_gnt_0", s_gnt, 2'b01);
      step(); s_req = 2'b10; #1;
      chk("t5_gnt_1", s_gnt, 2'b10);
      step(); s_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1; s_ack = 2'b00; #1;
      chk("t5_wait_ack",  m_ack,  0);
      chk("t5_wait_recv", s_recv, 2'b01);
      step(); s_ack = 2'b10; #1;
      chk("t5_wrong_ack", m_ack,  0);
      chk("t5_wrong_recv", s_recv, 2'b01);
      step(); s_ack = 2'b01; #1;
      chk("t5_ack0",  m_ack,  1);
      chk("t5_recv0", s_recv, 2'b01);
      step(); s_ack = 2'b10; m_error = 1'b1; m_rdata = 32'h5A5A_0002; #1;
      chk("t5_recv1",  s_recv,  2'b10);
      chk("t5_ack1",   m_ack,   1);
      chk("t5_error",  s_error, 2'b11);
      chk("t5_rdata",  s_rdata, 64'h5A5A_0002_5A5A_0002);
      step(); m_recv = 1'b0; s_ack = 2'b00; m_error = 1'b0;

      // 6: reset with an outstanding ID and a live lock
      s_req = 2'b01; m_gnt = 1'b1; #1;
      chk("t6_pre_gnt", s_gnt, 2'b01);
      step(); s_req = 2'b10; m_gnt = 1'b0; #1;
      chk("t6_pre_lock", m_req, 1);
      step(); g_resetn = 1'b0; s_req = 2'b00;
      step(); g_resetn = 1'b1; #1;
      chk("t6_rst_req", m_req, 0);
      step(); s_req = 2'b11; m_gnt = 1'b1; #1;
      chk("t6_gnt_a", s_gnt, 2'b01);
      step(); #1;
      chk("t6_req_b", m_req, 1);
      chk("t6_gnt_b", s_gnt, RR ? 2'b10 : 2'b01);
      step(); #1;
      chk("t6_full_req", m_req, 0);

      step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
